// File: rtl/mem_arbiter_if.sv
// Bundle of the two requester ports, the clear handshake and the memory command bus.
// The slave modport is the arbiter's view; master is the requesters' and memory's view.
interface mem_arbiter_if;
   logic        req0;
   logic        we0;
   logic [31:0] addr0;
   logic [31:0] wdata0;
   logic        done0;
   logic        err0;
   logic [31:0] rdata0;
   logic        req1;
   logic        we1;
   logic [31:0] addr1;
   logic [31:0] wdata1;
   logic        done1;
   logic        err1;
   logic [31:0] rdata1;
   logic        clr;
   logic        clr_done;
   logic        busy;
   logic [31:0] mem_addr;
   logic [31:0] mem_data;
   logic        mem_w;
   logic        mem_r;
   logic        mem_reset;
   logic [31:0] mem_rdata;

   modport slave (
      input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, clr, mem_rdata,
      output done0, err0, rdata0, done1, err1, rdata1, clr_done, busy,
             mem_addr, mem_data, mem_w, mem_r, mem_reset
   );

   modport master (
      output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, clr, mem_rdata,
      input  done0, err0, rdata0, done1, err1, rdata1, clr_done, busy,
             mem_addr, mem_data, mem_w, mem_r, mem_reset
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter that serialises read/write/clear requests onto a
// single-port memory with registered read data. Every output is a flop.
module mem_arbiter #(
   parameter int unsigned MEM_SIZE = 32
) (
   input logic         clk,
   input logic         reset,
   mem_arbiter_if.slave bus
);

   typedef enum logic [2:0] {StIdle, StClr, StCmd, StCapt, StDone} state_e;

   state_e      state_q, state_d;
   logic        ptr_q, ptr_d;
   logic        gnt_q, gnt_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        bad_q, bad_d;
   logic        clr_q, clr_d;
   logic        sel;
   logic        is_cmd, is_done;

   logic        done0_q, done0_d, done1_q, done1_d;
   logic        err0_q, err0_d, err1_q, err1_d;
   logic [31:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
   logic        clr_done_q, clr_done_d;
   logic        busy_q, busy_d;
   logic [31:0] mem_addr_q, mem_addr_d, mem_data_q, mem_data_d;
   logic        mem_w_q, mem_w_d, mem_r_q, mem_r_d, mem_reset_q, mem_reset_d;

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      gnt_d    = gnt_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      bad_d    = bad_q;
      clr_d    = clr_q;
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;
      sel      = ptr_q;
      unique case (state_q)
         StIdle: begin
            if (bus.clr) begin
               state_d = StClr;
               clr_d   = 1'b1;
            end else if (bus.req0 || bus.req1) begin
               // With both pending the pointer decides; otherwise the lone requester wins.
               sel     = (bus.req0 && bus.req1) ? ptr_q : bus.req1;
               gnt_d   = sel;
               we_d    = sel ? bus.we1 : bus.we0;
               addr_d  = sel ? bus.addr1 : bus.addr0;
               wdata_d = sel ? bus.wdata1 : bus.wdata0;
               bad_d   = (addr_d >= MEM_SIZE);
               clr_d   = 1'b0;
               state_d = bad_d ? StDone : StCmd;
            end
         end
         StClr:  state_d = StDone;
         StCmd:  state_d = we_q ? StDone : StCapt;
         StCapt: begin
            if (gnt_q) rdata1_d = bus.mem_rdata;
            else       rdata0_d = bus.mem_rdata;
            state_d = StDone;
         end
         StDone: begin
            state_d = StIdle;
            if (!clr_q) ptr_d = ~gnt_q;
         end
         default: state_d = StIdle;
      endcase

      // Outputs are decoded from the next state so they register in the cycle they belong to.
      is_cmd      = (state_d == StCmd);
      is_done     = (state_d == StDone);
      mem_addr_d  = is_cmd ? addr_d : '0;
      mem_data_d  = is_cmd ? wdata_d : '0;
      mem_w_d     = is_cmd && we_d;
      mem_r_d     = is_cmd && !we_d;
      mem_reset_d = (state_d == StClr);
      clr_done_d  = is_done && clr_d;
      done0_d     = is_done && !clr_d && !gnt_d;
      done1_d     = is_done && !clr_d && gnt_d;
      err0_d      = done0_d && bad_d;
      err1_d      = done1_d && bad_d;
      busy_d      = (state_d != StIdle);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         ptr_q       <= 1'b0;
         gnt_q       <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         bad_q       <= 1'b0;
         clr_q       <= 1'b0;
         done0_q     <= 1'b0;
         done1_q     <= 1'b0;
         err0_q      <= 1'b0;
         err1_q      <= 1'b0;
         rdata0_q    <= '0;
         rdata1_q    <= '0;
         clr_done_q  <= 1'b0;
         busy_q      <= 1'b0;
         mem_addr_q  <= '0;
         mem_data_q  <= '0;
         mem_w_q     <= 1'b0;
         mem_r_q     <= 1'b0;
         mem_reset_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         gnt_q       <= gnt_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         bad_q       <= bad_d;
         clr_q       <= clr_d;
         done0_q     <= done0_d;
         done1_q     <= done1_d;
         err0_q      <= err0_d;
         err1_q      <= err1_d;
         rdata0_q    <= rdata0_d;
         rdata1_q    <= rdata1_d;
         clr_done_q  <= clr_done_d;
         busy_q      <= busy_d;
         mem_addr_q  <= mem_addr_d;
         mem_data_q  <= mem_data_d;
         mem_w_q     <= mem_w_d;
         mem_r_q     <= mem_r_d;
         mem_reset_q <= mem_reset_d;
      end
   end

   assign bus.done0     = done0_q;
   assign bus.done1     = done1_q;
   assign bus.err0      = err0_q;
   assign bus.err1      = err1_q;
   assign bus.rdata0    = rdata0_q;
   assign bus.rdata1    = rdata1_q;
   assign bus.clr_done  = clr_done_q;
   assign bus.busy      = busy_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_data  = mem_data_q;
   assign bus.mem_w     = mem_w_q;
   assign bus.mem_r     = mem_r_q;
   assign bus.mem_reset = mem_reset_q;

endmodule
